// File: rtl/dly_seq_ctrl_if.sv
// Stream/config bundle for dly_seq_ctrl: enable, config strobe, sample in/out and status.
// The master side drives enable, config and input samples; the slave side is the sequencer.
interface dly_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
);
    logic             en;
    logic             cfg_load;
    logic [CW-1:0]    cfg_dly;
    logic             cfg_err;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic [15:0]      drop_cnt;

    modport master (
        output en, cfg_load, cfg_dly, din_valid, din,
        input  cfg_err, dout_valid, dout, busy, drop_cnt
    );

    modport slave (
        input  en, cfg_load, cfg_dly, din_valid, din,
        output cfg_err, dout_valid, dout, busy, drop_cnt
    );
endinterface

// File: rtl/dly_seq_ctrl.sv
// Programmable-depth {valid,data} delay line with IDLE/FILL/RUN sequencing and tag-based flush.
// Optional dropped-sample counter enabled by defining DLY_DROP_CNT_EN.
module dly_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_DLY = 16,
    parameter int CW      = 5,
    parameter int DEF_DLY = 3
) (
    input  logic         clk,
    input  logic         rst,
    dly_seq_ctrl_if.slave bus
);
    localparam int AW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

    state_e            state_q;
    logic [CW-1:0]     dly_q;
    logic [CW-1:0]     fill_cnt_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [MAX_DLY-1:0] tag_q;
    logic [WIDTH-1:0]  mem_q [MAX_DLY];
    logic [WIDTH-1:0]  dout_q;
    logic              dout_valid_q;
    logic              busy_q;
    logic              cfg_err_q;

    logic              cfg_ok;
    logic              live;
    logic [AW-1:0]     rd_idx;
    int                rd_sum;

    assign cfg_ok = bus.cfg_load && (bus.cfg_dly != '0) && (bus.cfg_dly <= CW'(MAX_DLY));
    // A live cycle writes one entry and reads the one written D cycles earlier.
    assign live   = (state_q != IDLE) && bus.en && !cfg_ok;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        rd_sum = int'(wr_ptr_q) + MAX_DLY - int'(dly_q);
        if (rd_sum >= MAX_DLY) rd_sum = rd_sum - MAX_DLY;
        rd_idx = AW'(rd_sum);
    end

    // NOTE: sample storage has no reset; the valid tags alone decide what may reach the output.
    always_ff @(posedge clk) begin
        if (live) mem_q[wr_ptr_q] <= bus.din;
    end

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dly_q        <= CW'(DEF_DLY);
            fill_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            tag_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q    <= bus.cfg_load && !cfg_ok;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            if (cfg_ok) dly_q <= bus.cfg_dly;

            if (!bus.en || cfg_ok) begin
                // Flush: in-flight samples are invalidated and the load-cycle sample is discarded.
                tag_q      <= '0;
                fill_cnt_q <= '0;
                state_q    <= bus.en ? FILL : IDLE;
                busy_q     <= bus.en;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= FILL;
                        fill_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                    FILL, RUN: begin
                        tag_q[wr_ptr_q] <= bus.din_valid;
                        wr_ptr_q        <= (wr_ptr_q == AW'(MAX_DLY - 1)) ? '0 : wr_ptr_q + AW'(1);
                        dout_valid_q    <= tag_q[rd_idx];
                        dout_q          <= tag_q[rd_idx] ? mem_q[rd_idx] : '0;
                        if (state_q == FILL && fill_cnt_q != dly_q - CW'(1)) begin
                            fill_cnt_q <= fill_cnt_q + CW'(1);
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_err    = cfg_err_q;

`ifdef DLY_DROP_CNT_EN
    localparam int VW = $clog2(MAX_DLY + 1);

    logic          en_q;
    logic [VW-1:0] vcnt_q;
    logic [15:0]   drop_q;
    logic [16:0]   drop_sum;

    assign drop_sum = {1'b0, drop_q} + 17'(vcnt_q) + 17'(bus.din_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            vcnt_q <= '0;
            drop_q <= '0;
        end else begin
            en_q <= bus.en;
            if (cfg_ok || (en_q && !bus.en)) begin
                vcnt_q <= '0;
                drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end else if (live) begin
                vcnt_q <= vcnt_q + VW'(bus.din_valid) - VW'(tag_q[rd_idx]);
            end else if (!bus.en) begin
                vcnt_q <= '0;
            end
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_dly_seq_ctrl.sv
// Self-checking bench for dly_seq_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a FIFO-based behavioural model.
module tb_dly_seq_ctrl;
    localparam int WIDTH   = 8;
    localparam int MAX_DLY = 16;
    localparam int CW      = 5;
    localparam int DEF_DLY = 3;
`ifdef DLY_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dly_seq_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    dly_seq_ctrl #(
        .WIDTH(WIDTH), .MAX_DLY(MAX_DLY), .CW(CW), .DEF_DLY(DEF_DLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the in-flight samples are a FIFO holding exactly the last D writes.
    typedef struct { bit v; logic [WIDTH-1:0] d; } samp_t;
    samp_t q[$];
    int    m_d      = DEF_DLY;
    bit    m_active = 1'b0;
    int    m_fill   = 0;
    bit    m_en_prev = 1'b0;
    int    m_drop   = 0;
    bit    e_dv, e_busy, e_err;
    logic [WIDTH-1:0] e_dout;

    task automatic model_step();
        bit    acc;
        int    nv;
        samp_t s;
        e_dv   = 1'b0;
        e_dout = '0;
        e_err  = 1'b0;
        if (rst) begin
            q.delete();
            m_d = DEF_DLY; m_active = 1'b0; m_fill = 0; m_en_prev = 1'b0; m_drop = 0;
        end else begin
            acc   = bus.cfg_load && bus.cfg_dly >= 1 && bus.cfg_dly <= MAX_DLY;
            e_err = bus.cfg_load && !acc;
            if (!bus.en || acc) begin
                if (acc || m_en_prev) begin
                    nv = int'(bus.din_valid);
                    foreach (q[i]) nv += int'(q[i].v);
                    m_drop = (m_drop + nv > 65535) ? 65535 : m_drop + nv;
                end
                q.delete();
                if (acc) m_d = int'(bus.cfg_dly);
                m_active = bus.en;
                m_fill   = bus.en ? m_d : 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_fill   = m_d;
            end else begin
                if (q.size() == m_d) begin
                    s      = q.pop_front();
                    e_dv   = s.v;
                    e_dout = s.v ? s.d : '0;
                end
                q.push_back('{bus.din_valid, bus.din});
                if (m_fill > 0) m_fill--;
            end
            m_en_prev = bus.en;
        end
        e_busy = m_active && (m_fill > 0);
    endtask

    always @(negedge clk) begin
        check("dout_valid", 32'(bus.dout_valid), 32'(e_dv));
        check("dout",       32'(bus.dout),       32'(e_dout));
        check("busy",       32'(bus.busy),       32'(e_busy));
        check("cfg_err",    32'(bus.cfg_err),    32'(e_err));
        check("drop_cnt",   32'(bus.drop_cnt),   DROP_EN ? 32'(m_drop) : 32'd0);
    end

    task automatic drive(input bit r, input bit e, input bit l, input logic [CW-1:0] dl,
                         input bit v, input logic [WIDTH-1:0] d);
        rst           = r;
        bus.en        = e;
        bus.cfg_load  = l;
        bus.cfg_dly   = dl;
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    bit               pv [6] = '{1, 0, 1, 1, 0, 0};
    logic [WIDTH-1:0] pd [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        bus.en = 1'b0; bus.cfg_load = 1'b0; bus.cfg_dly = '0; bus.din_valid = 1'b0; bus.din = '0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_dout_valid", 32'(bus.dout_valid), 0);
        check("rst_dout",       32'(bus.dout), 0);
        check("rst_busy",       32'(bus.busy), 0);
        check("rst_cfg_err",    32'(bus.cfg_err), 0);
        check("rst_drop",       32'(bus.drop_cnt), 0);

        // Start-up with default D=3: busy for 3 cycles, first sample out 3 cycles after it enters.
        drive(0, 1, 0, 0, 0, 0);
        check("t1_busy_e0", 32'(bus.busy), 1);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, 0, 0, 1, WIDTH'(i));
            check("t1_busy",  32'(bus.busy), (i < 3) ? 1 : 0);
            check("t1_valid", 32'(bus.dout_valid), (i >= 4) ? 1 : 0);
            check("t1_dout",  32'(bus.dout), (i >= 4) ? 32'(i - 3) : 0);
        end
        check("t1_model_dout", 32'(e_dout), 3);

        // Out-of-range loads are rejected without disturbing the stream.
        drive(0, 1, 1, 5'd0, 1, 8'd7);
        check("t3_err0", 32'(bus.cfg_err), 1);
        check("t3_dout0", 32'(bus.dout), 4);
        drive(0, 1, 0, 0, 1, 8'd8);
        check("t3_err_clr", 32'(bus.cfg_err), 0);
        check("t3_dout1", 32'(bus.dout), 5);
        drive(0, 1, 1, 5'd17, 1, 8'd9);
        check("t3_err17", 32'(bus.cfg_err), 1);
        check("t3_dout2", 32'(bus.dout), 6);
        drive(0, 1, 0, 0, 1, 8'd10);
        check("t3_dout3", 32'(bus.dout), 7);

        // Load D=16 in RUN: three valid samples in flight are dropped.
        drive(0, 1, 1, 5'd16, 0, 8'hAA);
        check("t2_valid_load", 32'(bus.dout_valid), 0);
        check("t2_model_drop", 32'(m_drop), 3);
        check("t2_drop", 32'(bus.drop_cnt), DROP_EN ? 3 : 0);
        for (int j = 0; j < 18; j++) begin
            drive(0, 1, 0, 0, 1, WIDTH'(8'h40 + j));
            check("t2_busy",  32'(bus.busy), (j < 15) ? 1 : 0);
            check("t2_valid", 32'(bus.dout_valid), (j >= 16) ? 1 : 0);
            check("t2_dout",  32'(bus.dout), (j >= 16) ? 32'(8'h40 + j - 16) : 0);
        end

        // D=1 with a sparse valid pattern.
        drive(0, 1, 1, 5'd1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, pv[i], pd[i]);
            check("t4_valid", 32'(bus.dout_valid), (i >= 1) ? 32'(pv[i-1]) : 0);
            check("t4_dout",  32'(bus.dout), (i >= 1 && pv[i-1]) ? 32'(pd[i-1]) : 0);
        end

        // en low for two cycles mid-stream, then refill.
        drive(0, 1, 0, 0, 1, 8'h60);
        drive(0, 1, 0, 0, 1, 8'h61);
        check("t5_pre", 32'(bus.dout), 8'h60);
        drive(0, 0, 0, 0, 1, 8'h62);
        check("t5_off_valid", 32'(bus.dout_valid), 0);
        drive(0, 0, 0, 0, 1, 8'h63);
        check("t5_off2_valid", 32'(bus.dout_valid), 0);
        drive(0, 1, 0, 0, 1, 8'h64);
        check("t5_refill_busy", 32'(bus.busy), 1);
        drive(0, 1, 0, 0, 1, 8'h65);
        check("t5_run_busy", 32'(bus.busy), 0);
        drive(0, 1, 0, 0, 1, 8'h66);
        check("t5_dout", 32'(bus.dout), 8'h65);
        check("t5_model_drop", 32'(m_drop), 21);
        check("t5_drop", 32'(bus.drop_cnt), DROP_EN ? 21 : 0);

        // Reset during FILL after loading D=8 restores D=3.
        drive(0, 1, 1, 5'd8, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, WIDTH'(8'h70 + i));
        drive(1, 1, 0, 0, 1, 8'h7F);
        check("t6_valid", 32'(bus.dout_valid), 0);
        check("t6_dout",  32'(bus.dout), 0);
        check("t6_busy",  32'(bus.busy), 0);
        check("t6_drop",  32'(bus.drop_cnt), 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 0, 0, 1, WIDTH'(8'h80 + i));
            check("t6_dout_d3", 32'(bus.dout), (i >= 4) ? 32'(8'h80 + i - 3) : 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 19) != 0,
                  $urandom_range(0, 29) == 0,
                  CW'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0,
                  WIDTH'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
